// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: a small FIFO of {pc,inst} entries
// with registered occupancy, no flow-through, and a whole-queue flush on redirect.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int BUS_W = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     IF_over,
  input  logic [BUS_W-1:0]         IF_ID_bus,
  output logic                     IF_fire,
  output logic                     IF_allow_in,
  output logic                     ID_valid,
  output logic [BUS_W-1:0]         ID_bus,
  input  logic                     ID_allow_in,
  output logic                     ID_fire,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;

  // Handshake: a transfer happens on a rising edge exactly when the sender's
  // valid (IF_over / ID_valid) and the receiver's ready (IF_allow_in /
  // ID_allow_in) are both high; the sender holds its data until then.
  // Fire strobes are masked during reset so fetch never advances its pc then.
  assign IF_allow_in = (cnt != FULL) && !flush;
  assign IF_fire     = resetn && IF_over && IF_allow_in;
  assign ID_valid    = (cnt != '0) && !flush;
  assign ID_fire     = resetn && ID_valid && ID_allow_in;
  assign ID_bus      = mem[rd_ptr];
  assign count       = cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (IF_fire) wr_ptr <= wr_ptr + 1'b1;
      if (ID_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({IF_fire, ID_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // IF_fire already excludes reset and flush, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (IF_fire) mem[wr_ptr] <= IF_ID_bus;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model sampled on the falling edge.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int BUS_W = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn;
  logic             IF_over;
  logic [BUS_W-1:0] IF_ID_bus;
  logic             IF_fire;
  logic             IF_allow_in;
  logic             ID_valid;
  logic [BUS_W-1:0] ID_bus;
  logic             ID_allow_in;
  logic             ID_fire;
  logic             flush;
  logic [CW-1:0]    count;

  int tests = 0;
  int fails = 0;
  logic [BUS_W-1:0] exp_q[$];
  logic last_if_fire = 1'b0;

  if_id_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk(clk), .resetn(resetn), .IF_over(IF_over), .IF_ID_bus(IF_ID_bus),
    .IF_fire(IF_fire), .IF_allow_in(IF_allow_in), .ID_valid(ID_valid),
    .ID_bus(ID_bus), .ID_allow_in(ID_allow_in), .ID_fire(ID_fire),
    .flush(flush), .count(count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the expected queue itself is the queue state.
  task automatic check_cycle();
    int sz;
    logic e_allow, e_push, e_valid, e_pop;
    logic [BUS_W-1:0] head;
    sz      = exp_q.size();
    e_allow = (sz < DEPTH) && !flush;
    e_push  = resetn && IF_over && e_allow;
    e_valid = (sz > 0) && !flush;
    e_pop   = resetn && e_valid && ID_allow_in;
    chk("count", 64'(count), 64'(sz));
    chk("IF_allow_in", 64'(IF_allow_in), 64'(e_allow));
    chk("IF_fire", 64'(IF_fire), 64'(e_push));
    chk("ID_valid", 64'(ID_valid), 64'(e_valid));
    chk("ID_fire", 64'(ID_fire), 64'(e_pop));
    last_if_fire = IF_fire;
    if (e_pop) begin
      head = exp_q.pop_front();
      chk("ID_bus_pop", ID_bus, head);
    end
    if (!resetn || flush) exp_q.delete();
    else if (e_push) exp_q.push_back(IF_ID_bus);
  endtask

  // monitor
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check_cycle();
    end
  end

  // driver tasks
  task automatic drive(input logic ov, input logic [BUS_W-1:0] bus,
                       input logic al, input logic fl);
    IF_over     = ov;
    IF_ID_bus   = bus;
    ID_allow_in = al;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && count != 0; k++) drive(1'b0, '0, 1'b1, 1'b0);
    chk("drain_count", 64'(count), 64'd0);
  endtask

  logic [BUS_W-1:0] cur;
  logic [31:0]      pc;
  logic             pend, ov, al, fl;

  initial begin
    resetn      = 1'b0;
    IF_over     = 1'b1;
    IF_ID_bus   = {32'hdeadbeef, 32'h0};
    ID_allow_in = 1'b0;
    flush       = 1'b0;

    // reset held two cycles with IF_over asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_IF_fire", 64'(IF_fire), 64'd0);
    chk("rst_ID_valid", 64'(ID_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    IF_over = 1'b0;
    resetn  = 1'b1;
    #1;
    chk("rst_IF_allow_in", 64'(IF_allow_in), 64'd1);

    // single pass
    drive(1'b1, {32'hbfc00000, 32'h24010001}, 1'b0, 1'b0);
    chk("single_valid", 64'(ID_valid), 64'd1);
    chk("single_bus", ID_bus, {32'hbfc00000, 32'h24010001});
    chk("single_count", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("single_pop_count", 64'(count), 64'd0);

    // fill and stall
    drive(1'b1, {32'hbfc00000, $urandom()}, 1'b0, 1'b0);
    drive(1'b1, {32'hbfc00004, $urandom()}, 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'd2);
    chk("fill_allow", 64'(IF_allow_in), 64'd0);
    chk("fill_fire", 64'(IF_fire), 64'd0);
    drive(1'b1, {32'hbfc00008, $urandom()}, 1'b1, 1'b0);
    chk("fill_pop_count", 64'(count), 64'd1);
    chk("fill_pop_allow", 64'(IF_allow_in), 64'd1);
    drain();

    // streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {32'hbfc00100 + 32'(4 * i), $urandom()}, 1'b1, 1'b0);
      chk("stream_count", 64'(count), 64'd1);
    end
    drain();

    // flush with a full queue and a pending push
    drive(1'b1, {32'hbfc00200, $urandom()}, 1'b0, 1'b0);
    drive(1'b1, {32'hbfc00204, $urandom()}, 1'b0, 1'b0);
    chk("flush_pre_count", 64'(count), 64'd2);
    drive(1'b1, {32'hbfc00208, $urandom()}, 1'b1, 1'b1);
    flush = 1'b0;
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(ID_valid), 64'd0);
    drive(1'b1, {32'hbfc00380, 32'h00000000}, 1'b0, 1'b0);
    chk("flush_head_pc", 64'(ID_bus[63:32]), 64'h00000000bfc00380);
    drain();

    // wrap: five push/pop pairs
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, {32'hbfc00000 + 32'(4 * i), $urandom()}, 1'b0, 1'b0);
      chk("wrap_head_pc", 64'(ID_bus[63:32]), 64'(32'hbfc00000 + 32'(4 * i)));
      drive(1'b0, '0, 1'b1, 1'b0);
    end

    // random traffic; fetch holds its entry until accepted
    pc   = 32'hbfc01000;
    pend = 1'b0;
    cur  = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        ov  = ($urandom_range(0, 3) != 0);
        cur = {pc, $urandom()};
      end else begin
        ov = 1'b1;
      end
      al     = ($urandom_range(0, 2) != 0);
      fl     = ($urandom_range(0, 19) == 0);
      resetn = ($urandom_range(0, 99) != 0);
      drive(ov, cur, al, fl);
      if (ov && last_if_fire) begin
        pc   = pc + 32'd4;
        pend = 1'b0;
      end else if (fl || !resetn) begin
        pc   = pc + 32'h100;
        pend = 1'b0;
      end else begin
        pend = ov;
      end
    end
    resetn = 1'b1;
    drain();
    @(negedge clk);
    #1;
    chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
